// File: rtl/vdp_host_port_master.sv
// vdp_host_port_master: timed csr_n/csw_n strobe master for the TMS9918 CPU port; VDP_HOST_INT_ACK_EN adds automatic status reads on vdp_int_n
module vdp_host_port_master #(
  parameter int STROBE_CYCLES   = 8,
  parameter int RECOVERY_CYCLES = 8
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [2:0]  req_op,
  input  logic [13:0] req_addr,
  input  logic [7:0]  req_data,
  output logic        rsp_valid,
  output logic [7:0]  rsp_data,
  output logic        vdp_csr_n,
  output logic        vdp_csw_n,
  output logic        vdp_mode,
  output logic [7:0]  vdp_cd_o,
  input  logic [7:0]  vdp_cd_i
`ifdef VDP_HOST_INT_ACK_EN
  ,
  input  logic        vdp_int_n,
  output logic [7:0]  int_status,
  output logic        int_valid
`endif
);
  typedef enum logic [1:0] {IDLE, SETUP, STROBE, RECOVER} state_t;
  state_t state, state_nx;
  logic [2:0]  op_q, sel_op;
  logic [13:0] addr_q, sel_addr;
  logic [7:0]  data_q, sel_data, cnt;
  logic        second, intop, start, start_int, int_pend, int_pend_nx;

  function automatic logic is_read(input logic [2:0] op);
    return op == 3'd1 || op == 3'd5;
  endfunction

  function automatic logic two_byte(input logic [2:0] op);
    return op == 3'd2 || op == 3'd3 || op == 3'd4;
  endfunction

  function automatic logic [7:0] byte_of(input logic [2:0] op, input logic [13:0] a, input logic [7:0] d, input logic sec);
    return !sec ? ((op == 3'd2 || op == 3'd3) ? a[7:0] : (op == 3'd0 || op == 3'd4) ? d : 8'h00)
         : (op == 3'd2) ? {2'b01, a[13:8]} : (op == 3'd3) ? {2'b00, a[13:8]} : {5'b10000, a[2:0]};
  endfunction

`ifdef VDP_HOST_INT_ACK_EN
  logic [2:0] int_sync;
  assign int_pend_nx = (int_sync[2] & ~int_sync[1]) | (int_pend & ~start_int);
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      int_sync <= 3'b111;
      int_pend <= 1'b0;
    end else begin
      int_sync <= {int_sync[1:0], vdp_int_n};
      int_pend <= int_pend_nx;
    end
  end
`else
  assign int_pend    = 1'b0;
  assign int_pend_nx = 1'b0;
`endif

  // In IDLE the incoming request (or the pending status read) selects the first byte
  always_comb begin
    start_int = state == IDLE && int_pend;
    start     = state == IDLE && (int_pend || (req_valid && req_ready));
    sel_op    = start_int ? 3'd5 : (state == IDLE) ? req_op : op_q;
    sel_addr  = (state == IDLE) ? req_addr : addr_q;
    sel_data  = (state == IDLE) ? req_data : data_q;
    state_nx  = state;
    case (state)
      IDLE:    state_nx = (start && sel_op <= 3'd5) ? SETUP : IDLE;
      SETUP:   state_nx = STROBE;
      STROBE:  state_nx = (cnt == 8'd0) ? RECOVER : STROBE;
      RECOVER: state_nx = (cnt != 8'd0) ? RECOVER : (two_byte(op_q) && !second) ? SETUP : IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state     <= IDLE;
      req_ready <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_data  <= 8'h00;
      vdp_csr_n <= 1'b1;
      vdp_csw_n <= 1'b1;
      vdp_mode  <= 1'b0;
      vdp_cd_o  <= 8'h00;
      cnt       <= 8'd0;
      op_q      <= 3'd0;
      addr_q    <= 14'd0;
      data_q    <= 8'h00;
      second    <= 1'b0;
      intop     <= 1'b0;
`ifdef VDP_HOST_INT_ACK_EN
      int_status <= 8'h00;
      int_valid  <= 1'b0;
`endif
    end else begin
      state     <= state_nx;
      req_ready <= state_nx == IDLE && !int_pend_nx;
      rsp_valid <= 1'b0;
      vdp_csr_n <= !(state_nx == STROBE && is_read(sel_op));
      vdp_csw_n <= !(state_nx == STROBE && !is_read(sel_op));
      cnt       <= (state == SETUP) ? 8'(STROBE_CYCLES - 1) : (state == STROBE && cnt == 8'd0) ? 8'(RECOVERY_CYCLES - 1) : (cnt != 8'd0) ? cnt - 8'd1 : cnt;
      if (start) begin
        op_q   <= sel_op;
        addr_q <= req_addr;
        data_q <= req_data;
        intop  <= start_int;
      end
      if (state_nx == SETUP) begin
        vdp_mode <= sel_op >= 3'd2;
        vdp_cd_o <= byte_of(sel_op, sel_addr, sel_data, state == RECOVER);
        second   <= state == RECOVER;
      end
`ifdef VDP_HOST_INT_ACK_EN
      int_valid <= 1'b0;
      if (state == STROBE && cnt == 8'd0 && is_read(op_q) && intop) begin
        int_status <= vdp_cd_i;
        int_valid  <= 1'b1;
      end
`endif
      if (state == STROBE && cnt == 8'd0 && is_read(op_q) && !intop) begin
        rsp_data  <= vdp_cd_i;
        rsp_valid <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_vdp_host_port_master.sv
// tb_vdp_host_port_master: directed bench with S=R=8 and a simple VDP read-data model
module tb_vdp_host_port_master;
  logic        clk, reset_n, req_valid, req_ready, rsp_valid;
  logic        vdp_csr_n, vdp_csw_n, vdp_mode;
  logic [2:0]  req_op;
  logic [13:0] req_addr;
  logic [7:0]  req_data, rsp_data, vdp_cd_o, vdp_cd_i, rd_byte;
  int          checks, errors, rd_pulses, rsp_cnt, overlap, n;
  logic [8:0]  wq[$];

  vdp_host_port_master #(.STROBE_CYCLES(8), .RECOVERY_CYCLES(8)) dut (
    .clk(clk), .reset_n(reset_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_addr(req_addr), .req_data(req_data),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .vdp_csr_n(vdp_csr_n), .vdp_csw_n(vdp_csw_n),
    .vdp_mode(vdp_mode), .vdp_cd_o(vdp_cd_o), .vdp_cd_i(vdp_cd_i)
  );

  assign vdp_cd_i = !vdp_csr_n ? rd_byte : 8'h00;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(negedge vdp_csw_n) wq.push_back({vdp_mode, vdp_cd_o});
  always @(negedge vdp_csr_n) rd_pulses++;
  always @(posedge clk) if (rsp_valid === 1'b1) rsp_cnt++;
  always @(negedge clk) if (vdp_csr_n === 1'b0 && vdp_csw_n === 1'b0) overlap++;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int k);
    for (int i = 0; i < k; i++) tick();
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic [2:0] op, input logic [13:0] a, input logic [7:0] d);
    req_op = op; req_addr = a; req_data = d; req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
  endtask

  // returns the cycle index (accept = 0) at which req_ready is seen high again
  task automatic wait_ready(output int cyc);
    cyc = 1;
    while (req_ready !== 1'b1 && cyc < 200) begin
      tick();
      cyc++;
    end
  endtask

  initial begin
    checks = 0; errors = 0; rd_pulses = 0; rsp_cnt = 0; overlap = 0;
    reset_n = 1'b0; req_valid = 1'b0; req_op = 3'd0; req_addr = 14'd0; req_data = 8'h00; rd_byte = 8'h00;
    ticks(3);
    chk("rst_csr_n", vdp_csr_n, 1'b1);
    chk("rst_csw_n", vdp_csw_n, 1'b1);
    chk("rst_mode", vdp_mode, 1'b0);
    chk("rst_cd", vdp_cd_o, 8'h00);
    chk("rst_rsp_valid", rsp_valid, 1'b0);
    chk("rst_ready_low", req_ready, 1'b0);
    reset_n = 1'b1;
    tick();
    chk("ready_after_release", req_ready, 1'b1);

    // WR_DATA 0xA5
    wq.delete();
    issue(3'd0, 14'd0, 8'hA5);
    chk("wr_c1_cd", vdp_cd_o, 8'hA5);
    chk("wr_c1_mode", vdp_mode, 1'b0);
    chk("wr_c1_csw_n", vdp_csw_n, 1'b1);
    chk("wr_c1_ready", req_ready, 1'b0);
    tick();
    chk("wr_c2_csw_n", vdp_csw_n, 1'b0);
    chk("wr_c2_csr_n", vdp_csr_n, 1'b1);
    ticks(7);
    chk("wr_c9_csw_n", vdp_csw_n, 1'b0);
    tick();
    chk("wr_c10_csw_n", vdp_csw_n, 1'b1);
    ticks(7);
    chk("wr_c17_ready", req_ready, 1'b0);
    chk("wr_c17_cd", vdp_cd_o, 8'hA5);
    tick();
    chk("wr_c18_ready", req_ready, 1'b1);
    chk("wr_pulses", 16'(wq.size()), 16'd1);

    // SET_WADDR 0x1234
    wq.delete(); rd_pulses = 0;
    issue(3'd2, 14'h1234, 8'h00);
    wait_ready(n);
    chk("waddr_latency", 16'(n), 16'd35);
    chk("waddr_pulses", 16'(wq.size()), 16'd2);
    if (wq.size() == 2) begin
      chk("waddr_b0", wq[0], {1'b1, 8'h34});
      chk("waddr_b1", wq[1], {1'b1, 8'h52});
    end
    chk("waddr_no_rd", 16'(rd_pulses), 16'd0);

    // WR_REG reg 7 data 0xF1
    wq.delete();
    issue(3'd4, 14'h0007, 8'hF1);
    wait_ready(n);
    chk("reg_latency", 16'(n), 16'd35);
    chk("reg_pulses", 16'(wq.size()), 16'd2);
    if (wq.size() == 2) begin
      chk("reg_b0", wq[0], {1'b1, 8'hF1});
      chk("reg_b1", wq[1], {1'b1, 8'h87});
    end

    // RD_DATA with the VDP returning 0x3C
    wq.delete(); rd_byte = 8'h3C;
    issue(3'd1, 14'd0, 8'h00);
    chk("rd_c1_mode", vdp_mode, 1'b0);
    ticks(8);
    chk("rd_c9_csr_n", vdp_csr_n, 1'b0);
    chk("rd_c9_rsp_valid", rsp_valid, 1'b0);
    tick();
    chk("rd_c10_rsp_valid", rsp_valid, 1'b1);
    chk("rd_c10_rsp_data", rsp_data, 8'h3C);
    chk("rd_c10_csr_n", vdp_csr_n, 1'b1);
    rd_byte = 8'h00;
    tick();
    chk("rd_c11_rsp_valid", rsp_valid, 1'b0);
    chk("rd_hold_data", rsp_data, 8'h3C);
    wait_ready(n);
    chk("rd_latency", 16'(n + 10), 16'd18);
    chk("rd_no_wr", 16'(wq.size()), 16'd0);

    // RD_STATUS with the VDP returning 0x9F
    rd_byte = 8'h9F;
    issue(3'd5, 14'd0, 8'h00);
    chk("st_c1_mode", vdp_mode, 1'b1);
    ticks(9);
    chk("st_c10_rsp_valid", rsp_valid, 1'b1);
    chk("st_c10_rsp_data", rsp_data, 8'h9F);
    wait_ready(n);

    // Reset during the first strobe of SET_RADDR
    issue(3'd3, 14'h2ABC, 8'h00);
    ticks(4);
    chk("abort_c5_csw_n", vdp_csw_n, 1'b0);
    reset_n = 1'b0;
    tick();
    chk("abort_csw_n", vdp_csw_n, 1'b1);
    chk("abort_csr_n", vdp_csr_n, 1'b1);
    chk("abort_ready", req_ready, 1'b0);
    reset_n = 1'b1;
    wq.delete(); rsp_cnt = 0;
    tick();
    chk("abort_ready_back", req_ready, 1'b1);
    ticks(40);
    chk("abort_no_2nd_byte", 16'(wq.size()), 16'd0);
    chk("abort_no_rsp", 16'(rsp_cnt), 16'd0);
    issue(3'd0, 14'd0, 8'h5A);
    wait_ready(n);
    chk("post_abort_latency", 16'(n), 16'd18);
    chk("post_abort_pulses", 16'(wq.size()), 16'd1);
    if (wq.size() == 1) chk("post_abort_byte", wq[0], {1'b0, 8'h5A});

    // Reserved op: no bus activity
    wq.delete(); rd_pulses = 0; rsp_cnt = 0;
    issue(3'd6, 14'h3FFF, 8'hFF);
    tick();
    chk("rsvd_ready", req_ready, 1'b1);
    ticks(20);
    chk("rsvd_no_wr", 16'(wq.size()), 16'd0);
    chk("rsvd_no_rd", 16'(rd_pulses), 16'd0);
    chk("rsvd_no_rsp", 16'(rsp_cnt), 16'd0);

    chk("no_strobe_overlap", 16'(overlap), 16'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
